// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with load/ready handshake.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load,
  output logic             ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             last_bit;

  assign accept   = load && ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a pending accept always wins at the end of a frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          if (accept) begin
            state_d = SHIFT;
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift toward the output end
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (accept) begin
      sr_d  = p_in;
      cnt_d = LAST;
    end else if (state_q == SHIFT) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef PISO_PARITY_EN
  logic par_q;

  // Even parity of the accepted word, held for the trailing bit
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^p_in;
    end
  end
`endif

  // Output decode from registered state only
  always_comb begin
    ready   = 1'b0;
    s_out   = 1'b0;
    s_valid = 1'b0;
    done    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        ready = 1'b1;
      end
      (state_q == SHIFT): begin
        s_valid = 1'b1;
        s_out   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
`ifndef PISO_PARITY_EN
        done    = (cnt_q == '0);
        ready   = (cnt_q == '0);
`endif
      end
`ifdef PISO_PARITY_EN
      (state_q == PARITY): begin
        s_valid = 1'b1;
        s_out   = par_q;
        done    = 1'b1;
        ready   = 1'b1;
      end
`endif
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer.
// Runs MSB-first and LSB-first instances on shared stimulus.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif
  localparam int N = 80;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] p_in = '0;

  logic rdy_a, so_a, sv_a, dn_a;
  logic rdy_b, so_b, sv_b, dn_b;

  int n_cmp = 0;
  int n_err = 0;

  bit           ld    [N];
  logic [W-1:0] pw    [N];
  logic [3:0]   exp_a [N];
  logic [3:0]   exp_b [N];
  logic [3:0]   obs_a [N];
  logic [3:0]   obs_b [N];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
    .clk     (clk),
    .clear_n (clear_n),
    .p_in    (p_in),
    .load    (load),
    .ready   (rdy_a),
    .s_out   (so_a),
    .s_valid (sv_a),
    .done    (dn_a)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
    .clk     (clk),
    .clear_n (clear_n),
    .p_in    (p_in),
    .load    (load),
    .ready   (rdy_b),
    .s_out   (so_b),
    .s_valid (sv_b),
    .done    (dn_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void clear_sched();
    for (int i = 0; i < N; i++) begin
      ld[i] = 1'b0;
      pw[i] = W'($urandom);
    end
  endfunction

  // Reference: a load in cycle c is taken if no frame is still busy;
  // its L bits fill cycles c+1..c+L; ready = idle or last-bit cycle.
  // Vector layout is {ready, s_valid, done, s_out}.
  function automatic void build(input int n);
    int           free_from;
    logic [W-1:0] word;
    logic         ba, bb, dn;
    free_from = 0;
    for (int c = 0; c < n; c++) begin
      exp_a[c] = 4'b1000;
      exp_b[c] = 4'b1000;
    end
    for (int c = 0; c < n; c++) begin
      if (ld[c] && c >= free_from) begin
        word = pw[c];
        for (int k = 0; k < L; k++) begin
          if (k < W) begin
            ba = word[W-1-k];
            bb = word[k];
          end else begin
            ba = ^word;
            bb = ^word;
          end
          dn = (k == L - 1);
          if (c + 1 + k < n) begin
            exp_a[c+1+k] = {dn, 1'b1, dn, ba};
            exp_b[c+1+k] = {dn, 1'b1, dn, bb};
          end
        end
        free_from = c + L;
      end
    end
  endfunction

  // Drive the schedule one cycle at a time, sample mid-cycle
  task automatic play(input int n);
    for (int c = 0; c < n; c++) begin
      load = ld[c];
      p_in = pw[c];
      @(negedge clk);
      obs_a[c] = {rdy_a, sv_a, dn_a, so_a};
      obs_b[c] = {rdy_b, sv_b, dn_b, so_b};
      @(posedge clk);
      #1;
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp += 2;
    if ({rdy_a, sv_a, dn_a, so_a} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_a: got rvds=%b want 1000",
               {rdy_a, sv_a, dn_a, so_a});
    end
    if ({rdy_b, sv_b, dn_b, so_b} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_b: got rvds=%b want 1000",
               {rdy_b, sv_b, dn_b, so_b});
    end
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp += 2;
    if ({rdy_a, sv_a, dn_a, so_a} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_rel_a: got rvds=%b want 1000",
               {rdy_a, sv_a, dn_a, so_a});
    end
    if ({rdy_b, sv_b, dn_b, so_b} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_rel_b: got rvds=%b want 1000",
               {rdy_b, sv_b, dn_b, so_b});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] want;
    logic [W-1:0] sipo_a, sipo_b;
    int           n;
    want = 4'b1011;
    n    = L + 4;
    clear_sched();
    ld[0] = 1'b1;
    pw[0] = want;
    build(n);
    play(n);
    for (int c = 0; c < n; c++) begin
      n_cmp += 2;
      if (obs_a[c] !== exp_a[c]) begin
        n_err++;
        $display("FAIL single_a c%0d: got rvds=%b want %b",
                 c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        n_err++;
        $display("FAIL single_b c%0d: got rvds=%b want %b",
                 c, obs_b[c], exp_b[c]);
      end
    end
    sipo_a = '0;
    sipo_b = '0;
    for (int k = 0; k < W; k++) begin
      n_cmp++;
      if (obs_a[1+k][0] !== want[W-1-k]) begin
        n_err++;
        $display("FAIL single_bit%0d: got %b want %b",
                 k, obs_a[1+k][0], want[W-1-k]);
      end
      sipo_a = {sipo_a[W-2:0], obs_a[1+k][0]};
      sipo_b = {obs_b[1+k][0], sipo_b[W-1:1]};
    end
    n_cmp += 2;
    if (sipo_a !== want) begin
      n_err++;
      $display("FAIL sipo_a: got %b want %b", sipo_a, want);
    end
    if (sipo_b !== want) begin
      n_err++;
      $display("FAIL sipo_b: got %b want %b", sipo_b, want);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 2 * L + 4;
    clear_sched();
    for (int c = 0; c <= L; c++) begin
      ld[c] = 1'b1;
      pw[c] = 4'b1011;
    end
    pw[L] = 4'b0110;
    build(n);
    play(n);
    for (int c = 0; c < n; c++) begin
      n_cmp += 2;
      if (obs_a[c] !== exp_a[c]) begin
        n_err++;
        $display("FAIL b2b_a c%0d: got rvds=%b want %b",
                 c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        n_err++;
        $display("FAIL b2b_b c%0d: got rvds=%b want %b",
                 c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_busy_load();
    int n;
    n = L + 4;
    clear_sched();
    ld[0] = 1'b1;
    pw[0] = 4'b1011;
    ld[2] = 1'b1;
    pw[2] = 4'b0000;
    build(n);
    play(n);
    for (int c = 0; c < n; c++) begin
      n_cmp += 2;
      if (obs_a[c] !== exp_a[c]) begin
        n_err++;
        $display("FAIL busy_a c%0d: got rvds=%b want %b",
                 c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        n_err++;
        $display("FAIL busy_b c%0d: got rvds=%b want %b",
                 c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] lsb_seq;
    load = 1'b1;
    p_in = 4'b1011;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    n_cmp += 2;
    if ({rdy_a, sv_a, dn_a, so_a} !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_a: got rvds=%b want 1000",
               {rdy_a, sv_a, dn_a, so_a});
    end
    if ({rdy_b, sv_b, dn_b, so_b} !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_b: got rvds=%b want 1000",
               {rdy_b, sv_b, dn_b, so_b});
    end
    @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    clear_sched();
    build(8);
    play(8);
    for (int c = 0; c < 8; c++) begin
      n_cmp += 2;
      if (obs_a[c] !== exp_a[c]) begin
        n_err++;
        $display("FAIL postrst_a c%0d: got rvds=%b want %b",
                 c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        n_err++;
        $display("FAIL postrst_b c%0d: got rvds=%b want %b",
                 c, obs_b[c], exp_b[c]);
      end
    end
    clear_sched();
    ld[0] = 1'b1;
    pw[0] = 4'b1011;
    build(L + 4);
    play(L + 4);
    for (int c = 0; c < L + 4; c++) begin
      n_cmp += 2;
      if (obs_a[c] !== exp_a[c]) begin
        n_err++;
        $display("FAIL reload_a c%0d: got rvds=%b want %b",
                 c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        n_err++;
        $display("FAIL reload_b c%0d: got rvds=%b want %b",
                 c, obs_b[c], exp_b[c]);
      end
    end
    lsb_seq = 4'b1011;
    for (int k = 0; k < W; k++) begin
      n_cmp++;
      if (obs_b[1+k][0] !== lsb_seq[k]) begin
        n_err++;
        $display("FAIL lsb_bit%0d: got %b want %b",
                 k, obs_b[1+k][0], lsb_seq[k]);
      end
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic         pbit  [2];
    words[0] = 4'b1011;
    pbit[0]  = 1'b1;
    words[1] = 4'b0110;
    pbit[1]  = 1'b0;
    for (int t = 0; t < 2; t++) begin
      clear_sched();
      ld[0] = 1'b1;
      pw[0] = words[t];
      play(L + 3);
      n_cmp += 2;
      if (obs_a[L] !== {1'b1, 1'b1, 1'b1, pbit[t]}) begin
        n_err++;
        $display("FAIL parity_a w%0d: got rvds=%b want %b",
                 t, obs_a[L], {3'b111, pbit[t]});
      end
      if (obs_a[L-1][1] !== 1'b0) begin
        n_err++;
        $display("FAIL parity_done_early w%0d: got %b want 0",
                 t, obs_a[L-1][1]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      clear_sched();
      for (int c = 0; c < N - L - 2; c++) begin
        ld[c] = ($urandom_range(0, 2) == 0);
      end
      build(N);
      play(N);
      for (int c = 0; c < N; c++) begin
        n_cmp += 2;
        if (obs_a[c] !== exp_a[c]) begin
          n_err++;
          $display("FAIL rand%0d_a c%0d: got rvds=%b want %b",
                   it, c, obs_a[c], exp_a[c]);
        end
        if (obs_b[c] !== exp_b[c]) begin
          n_err++;
          $display("FAIL rand%0d_b c%0d: got rvds=%b want %b",
                   it, c, obs_b[c], exp_b[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_load();
    test_reset_midframe();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
